// File: rtl/fetch_sequencer.sv
// Program-fetch controller: owns the PC, the Start/Ack run handshake, program
// base selection, relative/absolute branching, stall, cycle count and watchdog.
module fetch_sequencer #(
  parameter int                       PC_W       = 10,
  parameter int                       PROG_CNT   = 4,
  parameter logic [PROG_CNT*PC_W-1:0] BASE_ADDRS = {10'd768, 10'd512, 10'd256, 10'd0},
  parameter int                       CYC_W      = 16,
  parameter int                       WDOG_LIMIT = 0
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic [$clog2(PROG_CNT)-1:0] ProgSel,
  input  logic                        Halt,
  input  logic                        Stall,
  input  logic                        BranchEn,
  input  logic                        BranchAbs,
  input  logic [PC_W-1:0]             Target,
  output logic [PC_W-1:0]             ProgCtr,
  output logic                        Running,
  output logic                        Ack,
  output logic                        Timeout,
  output logic [CYC_W-1:0]            CycleCt
);

  localparam int SEL_W = $clog2(PROG_CNT);
  localparam logic [CYC_W-1:0] WDOG_LAST = CYC_W'(WDOG_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   prog_ctr_q, prog_ctr_d;
  logic [CYC_W-1:0]  cycle_ct_q, cycle_ct_d;
  logic              timeout_q, timeout_d;
  logic              running_q, running_d;
  logic              ack_q, ack_d;

  logic [PC_W-1:0]   base_addr;
  logic [CYC_W-1:0]  cycle_ct_inc;
  logic              wdog_hit;

  // Out-of-range selects fall back to program 0.
  function automatic logic [PC_W-1:0] base_of(input logic [SEL_W-1:0] sel);
    base_of = BASE_ADDRS[0 +: PC_W];
    for (int i = 1; i < PROG_CNT; i++) begin
      if (int'(sel) == i) base_of = BASE_ADDRS[i*PC_W +: PC_W];
    end
  endfunction

  assign base_addr    = base_of(ProgSel);
  assign cycle_ct_inc = (&cycle_ct_q) ? cycle_ct_q : cycle_ct_q + CYC_W'(1);
  assign wdog_hit     = (WDOG_LIMIT != 0) && (cycle_ct_q == WDOG_LAST);

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    state_d    = state_q;
    prog_ctr_d = prog_ctr_q;
    cycle_ct_d = cycle_ct_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      IDLE, LOAD: begin
        prog_ctr_d = base_addr;
        cycle_ct_d = '0;
        timeout_d  = 1'b0;
        if (state_q == IDLE && Start)      state_d = LOAD;
        else if (state_q == LOAD && !Start) state_d = RUN;
      end
      RUN: begin
        cycle_ct_d = cycle_ct_inc;
        if (Halt) begin
          state_d = DONE;
        end else if (wdog_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else if (Stall) begin
          prog_ctr_d = prog_ctr_q;
        end else if (BranchEn) begin
          // Relative offsets are already PC_W wide, so modular addition sign-extends for free.
          prog_ctr_d = BranchAbs ? Target : prog_ctr_q + Target;
        end else begin
          prog_ctr_d = prog_ctr_q + PC_W'(1);
        end
      end
      DONE: begin
        if (Start) begin
          state_d    = LOAD;
          prog_ctr_d = base_addr;
          cycle_ct_d = '0;
          timeout_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN);
    ack_d     = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    if (Reset) begin
      state_q    <= IDLE;
      prog_ctr_q <= '0;
      cycle_ct_q <= '0;
      timeout_q  <= 1'b0;
      running_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_ctr_q <= prog_ctr_d;
      cycle_ct_q <= cycle_ct_d;
      timeout_q  <= timeout_d;
      running_q  <= running_d;
      ack_q      <= ack_d;
    end
  end

  assign ProgCtr = prog_ctr_q;
  assign Running = running_q;
  assign Ack     = ack_q;
  assign Timeout = timeout_q;
  assign CycleCt = cycle_ct_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a default instance plus a WDOG_LIMIT=8
// instance share stimulus; each step queues the expected outputs after the edge.
module tb_fetch_sequencer;

  logic       Clk = 1'b0;
  logic       Reset, Start, Halt, Stall, BranchEn, BranchAbs;
  logic [1:0] ProgSel;
  logic [9:0] Target;

  logic [9:0]  pc_a, pc_w;
  logic        run_a, run_w, ack_a, ack_w, to_a, to_w;
  logic [15:0] ct_a, ct_w;

  fetch_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
    .Stall(Stall), .BranchEn(BranchEn), .BranchAbs(BranchAbs), .Target(Target),
    .ProgCtr(pc_a), .Running(run_a), .Ack(ack_a), .Timeout(to_a), .CycleCt(ct_a)
  );

  fetch_sequencer #(.WDOG_LIMIT(8)) dut_wd (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
    .Stall(Stall), .BranchEn(BranchEn), .BranchAbs(BranchAbs), .Target(Target),
    .ProgCtr(pc_w), .Running(run_w), .Ack(ack_w), .Timeout(to_w), .CycleCt(ct_w)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string tag;
    bit    wd;
    int    pc, run, ack, to, ct;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue what must appear after the edge, then compare.
  task automatic step(input string tag, input bit wd, input bit rst, input bit st,
                      input int sel, input bit hl, input bit sl, input bit be,
                      input bit ba, input int tg, input int pc, input int run,
                      input int ack, input int to, input int ct);
    exp_t e;
    Reset = rst; Start = st; ProgSel = 2'(sel); Halt = hl; Stall = sl;
    BranchEn = be; BranchAbs = ba; Target = 10'(tg);
    sb.push_back('{tag, wd, pc, run, ack, to, ct});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    if (e.wd) begin
      check({e.tag, ".pc"}, 32'(pc_w), e.pc);
      check({e.tag, ".run"}, 32'(run_w), e.run);
      check({e.tag, ".ack"}, 32'(ack_w), e.ack);
      check({e.tag, ".to"}, 32'(to_w), e.to);
      check({e.tag, ".ct"}, 32'(ct_w), e.ct);
    end else begin
      check({e.tag, ".pc"}, 32'(pc_a), e.pc);
      check({e.tag, ".run"}, 32'(run_a), e.run);
      check({e.tag, ".ack"}, 32'(ack_a), e.ack);
      check({e.tag, ".to"}, 32'(to_a), e.to);
      check({e.tag, ".ct"}, 32'(ct_a), e.ct);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not finish");
    $fatal(1, "time limit expired");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; ProgSel = '0; Halt = 1'b0; Stall = 1'b0;
    BranchEn = 1'b0; BranchAbs = 1'b0; Target = '0;
    @(posedge Clk);
    #1;

    // Reset, then load program 1 and run to a halt at PC 260.
    step("rst0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("load1", 0, 0, 1, 1, 0, 0, 0, 0, 0, 256, 0, 0, 0, 0);
    step("run1", 0, 0, 0, 1, 0, 0, 0, 0, 0, 256, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      step("adv1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 256 + i, 1, 0, 0, i);
    step("halt1", 0, 0, 0, 0, 1, 0, 0, 0, 0, 260, 0, 1, 0, 5);
    step("done_ignore", 0, 0, 0, 0, 1, 0, 1, 1, 7, 260, 0, 1, 0, 5);

    // Restart into program 2, branching, stall, wrap, Halt beats Stall.
    step("restart2", 0, 0, 1, 2, 0, 0, 0, 0, 0, 512, 0, 0, 0, 0);
    step("run2", 0, 0, 0, 2, 0, 0, 0, 0, 0, 512, 1, 0, 0, 0);
    step("br_abs300", 0, 0, 0, 0, 0, 0, 1, 1, 300, 300, 1, 0, 0, 1);
    step("br_rel_m4", 0, 0, 0, 0, 0, 0, 1, 0, 'h3FC, 296, 1, 0, 0, 2);
    step("br_abs5", 0, 0, 0, 0, 0, 0, 1, 1, 5, 5, 1, 0, 0, 3);
    for (int i = 0; i < 3; i++)
      step("stall", 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 1, 0, 0, 4 + i);
    step("stall_over_br", 0, 0, 0, 0, 0, 1, 1, 1, 100, 5, 1, 0, 0, 7);
    step("br_abs3ff", 0, 0, 0, 0, 0, 0, 1, 1, 'h3FF, 1023, 1, 0, 0, 8);
    step("wrap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9);
    step("halt_stall", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 10);

    // Program 3, reset asserted at CycleCt=3 with Start also high.
    step("load3", 0, 0, 1, 3, 0, 0, 0, 0, 0, 768, 0, 0, 0, 0);
    step("run3", 0, 0, 0, 3, 0, 0, 0, 0, 0, 768, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++)
      step("adv3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 768 + i, 1, 0, 0, i);
    step("rst_mid", 0, 1, 1, 3, 1, 0, 1, 1, 5, 0, 0, 0, 0, 0);

    // Watchdog instance: fires after exactly 8 RUN cycles.
    step("wd_load", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("wd_run", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++)
      step("wd_adv", 1, 0, 0, 0, 0, 0, 0, 0, 0, i, 1, 0, 0, i);
    step("wd_fire", 1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 1, 8);
    step("wd_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 1, 8);
    step("wd_restart", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("wd_run2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++)
      step("wd_adv2", 1, 0, 0, 0, 0, 0, 0, 0, 0, i, 1, 0, 0, i);
    step("wd_halt_wins", 1, 0, 0, 0, 1, 0, 0, 0, 0, 7, 0, 1, 0, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Parametrised program-fetch controller for the 9-bit-instruction processor family. It owns the program counter, the Start/Ack run handshake, multi-program base selection, relative and absolute branching, stall support, a run-cycle counter and a watchdog timeout. It sits between the testbench/top-level handshake and the instruction ROM, and replaces the separate PC-enable and PC blocks of the previous generation.

## Interface
Parameters:
- PC_W, 10, program counter width; the ROM address space is 2^PC_W.
- PROG_CNT, 4, number of selectable programs.
- BASE_ADDRS, {10'd768,10'd512,10'd256,10'd0}, packed PROG_CNT*PC_W vector. Entry i sits at bits [i*PC_W +: PC_W].
- CYC_W, 16, cycle counter width.
- WDOG_LIMIT, 0, maximum number of RUN cycles before forced completion; 0 disables the watchdog.

Ports:
- Clk  in  1  clock; all state changes on the posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  run request from the testbench/top level (level-sensitive).
- ProgSel  in  $clog2(PROG_CNT)  program index, sampled while in LOAD.
- Halt  in  1  decoder reports a halt/done instruction at the current PC.
- Stall  in  1  freezes the PC for this cycle.
- BranchEn  in  1  take a branch this cycle.
- BranchAbs  in  1  1 = absolute target, 0 = PC-relative.
- Target  in  PC_W  absolute address, or two's-complement offset.
- ProgCtr  out  PC_W  registered PC, drives the instruction ROM address.
- Running  out  1  high in RUN; PC advance is qualified by it.
- Ack  out  1  done flag, high in DONE.
- Timeout  out  1  DONE was reached via the watchdog.
- CycleCt  out  CYC_W  RUN cycles elapsed in the current program.

## Operation
- Four-state FSM: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - Start=1 -> LOAD.
  - ProgCtr is loaded with BASE[ProgSel], CycleCt is cleared to 0 and Timeout is cleared to 0.
- **LOAD**
  - While Start=1: stay in LOAD and reload ProgCtr from BASE[ProgSel] every cycle; the last value wins.
  - Start=0 -> RUN.
- **RUN**, evaluated in priority order:
  1. Halt -> DONE; PC holds.
  2. Watchdog (WDOG_LIMIT≠0 and CycleCt==WDOG_LIMIT-1) -> DONE with Timeout=1; PC holds.
  3. Stall -> PC holds.
  4. BranchEn -> PC = BranchAbs ? Target : PC+Target.
  5. Otherwise -> PC+1.
- CycleCt increments on every RUN cycle, including stalled and halting cycles, and saturates at all-ones.
- Start is ignored in RUN.
- **DONE**
  - Ack=1; PC, CycleCt and Timeout hold.
  - Start=1 -> LOAD, which clears Ack and CycleCt and reloads the PC as described for IDLE.
- Arithmetic: all PC sums are modulo 2^PC_W. Relative Target is sign-extended to PC_W, which is already its native width. 10'h3FF+1 wraps to 0.
- ProgSel ≥ PROG_CNT selects BASE[0].
- Halt or BranchEn asserted outside RUN has no effect.

## Timing
- Reset values: state IDLE, ProgCtr=0, Running=0, Ack=0, Timeout=0, CycleCt=0. Reset takes priority over all inputs in any state.
- Latencies:
  - Start high in IDLE/DONE: one cycle later, state=LOAD and ProgCtr=BASE[ProgSel].
  - Start low in LOAD: one cycle later, state=RUN and Running=1.
  - Halt in RUN: one cycle later, Ack=1 and Running=0.
- Zero-latency branch: a branch decided in cycle n sets ProgCtr in cycle n+1.
- Reset asserted mid-RUN: the next cycle is IDLE with all outputs at their reset values.
- Halt and Stall asserted together: Halt wins.
- Halt and the watchdog condition in the same cycle: Halt wins, so Timeout=0.

## Test plan
- **Reset/run.** Reset 2 cycles, then Start 3 cycles with ProgSel=1, then Start low.
  - Required: ProgCtr=256 during LOAD; ProgCtr 257, 258, 259 on successive RUN cycles.
  - Halt at PC=260: Ack=1 next cycle, CycleCt=5.
- **Branching.** In RUN at PC=300:
  - BranchEn, relative, Target=10'h3FC (-4) -> next PC=296.
  - Then BranchAbs with Target=5 -> next PC=5.
  - Stall for 3 cycles -> PC stays at 5 while CycleCt advances by 3.
- **Wrap.** BranchAbs to 10'h3FF, then a normal advance -> PC=0.
- **Watchdog.** WDOG_LIMIT=8, no Halt -> after exactly 8 RUN cycles Ack=1, Timeout=1 and CycleCt=8.
- **Restart and precedence.**
  - Start raised in DONE with ProgSel=2 -> PC=512, Ack=0, Timeout=0, CycleCt=0.
  - Halt and Stall together -> DONE.
- **Reset mid-run.** Reset asserted at CycleCt=3 -> next cycle state IDLE, ProgCtr=0, CycleCt=0, Ack=0.
